// File: rtl/csr_tohost_reader.sv
`default_nettype none
// ============================================================================
// Module      : csr_tohost_reader
// Description : Snoops EX-stage CSR writes to tohost, buffers them in a FIFO,
//               streams them out and decodes the termination word.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_tohost_reader #(
    parameter int          DWIDTH      = 32,
    parameter int          DEPTH       = 4,
    parameter logic [11:0] TOHOST_ADDR = 12'h51E
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     csr_we,
    input  logic [11:0]              csr_addr,
    input  logic [DWIDTH-1:0]        csr_wdata,
    output logic                     out_valid,
    output logic [DWIDTH-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     done,
    output logic                     pass,
    output logic [DWIDTH-2:0]        fail_code
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH_CNT = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_term;

    logic [DWIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]       r_rptr;
    logic [AW-1:0]       r_wptr;
    logic [AW:0]         r_count;
    logic                r_overflow;
    logic                r_done;
    logic                r_pass;
    logic [DWIDTH-2:0]   r_fail_code;

    logic                w_capture;
    logic                w_full;
    logic                w_pop;
    logic                w_push;

    assign w_capture = csr_we && (csr_addr == TOHOST_ADDR) && (r_state == ST_RUN);
    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_pop     = out_valid && out_ready;
    // A full FIFO still accepts a capture when the head leaves in the same cycle
    assign w_push    = w_capture && (!w_full || w_pop);

    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rptr];
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_code = r_fail_code;

    always_comb begin
        w_state_nxt = r_state;
        w_term      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_capture && csr_wdata[0]) begin
                    w_state_nxt = ST_DONE;
                    w_term      = 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else if (clear) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rptr      <= '0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_code <= '0;
        end else if (clear) begin
            r_rptr      <= '0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_code <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_capture && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_term) begin
                r_done      <= 1'b1;
                r_pass      <= (csr_wdata == DWIDTH'(1));
                r_fail_code <= csr_wdata[DWIDTH-1:1];
            end
        end
    end

    // Storage needs no reset: a slot is only observed after it has been written
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= csr_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_tohost_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_tohost_reader
// Description : Scoreboard bench for csr_tohost_reader with directed and
//               randomized CSR write traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_tohost_reader;

    localparam int          DW     = 32;
    localparam int          DEPTH  = 4;
    localparam logic [11:0] TOHOST = 12'h51E;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          csr_we = 1'b0;
    logic [11:0]   csr_addr = '0;
    logic [DW-1:0] csr_wdata = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b1;
    logic [2:0]    count;
    logic          overflow;
    logic          done;
    logic          pass;
    logic [DW-2:0] fail_code;

    csr_tohost_reader #(
        .DWIDTH      (DW),
        .DEPTH       (DEPTH),
        .TOHOST_ADDR (TOHOST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .csr_we    (csr_we),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .done      (done),
        .pass      (pass),
        .fail_code (fail_code)
    );

    always #5 clk = ~clk;

    // Reference model: queue of buffered words plus status flags
    logic [DW-1:0] sb_q[$];
    logic          m_done = 1'b0;
    logic          m_pass = 1'b0;
    logic [DW-2:0] m_fail = '0;
    logic          m_ovf  = 1'b0;

    logic          pend_clr  = 1'b0;
    logic          pend_push = 1'b0;
    logic          pend_ovf  = 1'b0;
    logic          pend_term = 1'b0;
    logic [DW-1:0] pend_data = '0;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  mon_en   = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_flush();
        sb_q.delete();
        m_done = 1'b0;
        m_pass = 1'b0;
        m_fail = '0;
        m_ovf  = 1'b0;
    endtask

    // Apply the effect of the edge that just passed
    task automatic commit();
        if (pend_clr) begin
            model_flush();
        end else begin
            if (pend_push) sb_q.push_back(pend_data);
            if (pend_ovf)  m_ovf = 1'b1;
            if (pend_term) begin
                m_done = 1'b1;
                m_pass = (pend_data == 32'd1);
                m_fail = pend_data[DW-1:1];
            end
        end
        pend_clr  = 1'b0;
        pend_push = 1'b0;
        pend_ovf  = 1'b0;
        pend_term = 1'b0;
    endtask

    task automatic step(input logic we, input logic [11:0] addr, input logic [DW-1:0] wd,
                        input logic rdy, input logic clr, input logic rst);
        bit cap;
        bit popp;
        @(posedge clk);
        #1;
        commit();
        csr_we    = we;
        csr_addr  = addr;
        csr_wdata = wd;
        out_ready = rdy;
        clear     = clr;
        if (rst) begin
            rst_n = 1'b0;
            model_flush();
        end else begin
            rst_n     = 1'b1;
            cap       = we && (addr == TOHOST) && !m_done;
            popp      = (sb_q.size() > 0) && rdy;
            pend_clr  = clr;
            pend_push = cap && ((sb_q.size() < DEPTH) || popp);
            pend_ovf  = cap && (sb_q.size() == DEPTH) && !popp;
            pend_term = cap && wd[0];
            pend_data = wd;
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 12'h000, '0, rdy, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [DW-1:0] wd, input logic rdy);
        step(1'b1, addr, wd, rdy, 1'b0, 1'b0);
    endtask

    // Monitor: compares the DUT against the model mid-cycle and retires handshakes
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count",     DW'(count),     DW'(sb_q.size()));
            chk("out_valid", DW'(out_valid), DW'(sb_q.size() != 0));
            if (out_valid && sb_q.size() != 0) chk("out_data", out_data, sb_q[0]);
            chk("overflow",  DW'(overflow),  DW'(m_ovf));
            chk("done",      DW'(done),      DW'(m_done));
            chk("pass",      DW'(pass),      DW'(m_pass));
            chk("fail_code", DW'(fail_code), DW'(m_fail));
            if (rst_n && !clear && out_ready && sb_q.size() != 0) begin
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        int r;
        logic [DW-1:0] wd;
        logic [11:0]   ad;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        // reset held with out_ready high
        step(1'b0, 12'h000, '0, 1'b1, 1'b0, 1'b1);

        // single word, held stable, then drained
        wr(TOHOST, 32'h0000_0042, 1'b0);
        repeat (3) idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // other addresses ignored
        wr(12'h340, 32'h5, 1'b1);
        idle(1'b0);

        // overflow: five writes with no consumer
        for (int i = 0; i < 5; i++) wr(TOHOST, 32'hA0 + 32'(2*i), 1'b0);
        repeat (5) idle(1'b1);
        step(1'b0, 12'h000, '0, 1'b0, 1'b1, 1'b0);
        // full FIFO with a pop in the same cycle accepts the fifth word
        for (int i = 0; i < 4; i++) wr(TOHOST, 32'hB0 + 32'(2*i), 1'b0);
        wr(TOHOST, 32'hC0, 1'b1);
        idle(1'b0);
        repeat (5) idle(1'b1);

        // pass termination then a blocked write
        wr(TOHOST, 32'h1, 1'b0);
        wr(TOHOST, 32'h8, 1'b0);
        repeat (3) idle(1'b1);

        // fail termination, then clear
        step(1'b0, 12'h000, '0, 1'b0, 1'b1, 1'b0);
        wr(TOHOST, 32'h7, 1'b0);
        idle(1'b0);
        step(1'b0, 12'h000, '0, 1'b1, 1'b1, 1'b0);
        idle(1'b0);

        // reset mid-stream discards buffered words
        wr(TOHOST, 32'h10, 1'b0);
        wr(TOHOST, 32'h12, 1'b0);
        step(1'b0, 12'h000, '0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(99));
            ad = ($urandom_range(9) < 6) ? TOHOST : 12'($urandom);
            wd = $urandom & ~32'h1;
            if ($urandom_range(29) == 0) wd = ($urandom_range(2) == 0) ? 32'h1 : ($urandom | 32'h1);
            if (r < 2) begin
                step(1'b0, 12'h000, '0, 1'($urandom), 1'b0, 1'b1);
            end else if (r < 5) begin
                step(1'($urandom), ad, wd, 1'($urandom), 1'b1, 1'b0);
            end else begin
                step(1'($urandom_range(3) != 0), ad, wd, 1'($urandom), 1'b0, 1'b0);
            end
        end
        repeat (6) idle(1'b1);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
